mem_responder: RTL and testbench

- Memory-side responder for the multicycle rv32i core's data/instruction memory port.
- Accepts one read or write request at a time from the core's control/datapath (mem_RE / mem_WE style strobes plus address, write data and byte enables).
- Inserts a configurable number of wait states, then returns read data or a write acknowledge with an error flag.
- Replaces the zero-latency internal memory so the core's FSM can be exercised against a realistic slow memory.

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port memory responder with configurable wait states.
// One request in flight; errors still take the full latency.
module mem_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_re,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [CW-1:0] CLAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] a_idx;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;
  logic          a_we;
  logic          a_err;

  logic          req;
  logic          req_err;
  logic [AW-1:0] req_idx;

  logic          go;
  logic          op_we;
  logic          op_err;
  logic [AW-1:0] op_idx;
  logic [31:0]   op_wdata;
  logic [3:0]    op_be;

  assign req     = req_re | req_we;
  assign req_idx = req_addr[AW+1:2];
  assign req_err = (req_addr[1:0] != 2'b00)
                 | ({1'b0, req_addr} >= LIMIT)
                 | (req_re & req_we);

  // With zero latency the accepting edge is also the edge entering RESP,
  // so the operation must come straight from the request inputs.
  always_comb begin
    go       = 1'b0;
    op_we    = a_we;
    op_err   = a_err;
    op_idx   = a_idx;
    op_wdata = a_wdata;
    op_be    = a_be;
    if (state == IDLE && req && LATENCY == 0) begin
      go       = 1'b1;
      op_we    = req_we;
      op_err   = req_err;
      op_idx   = req_idx;
      op_wdata = req_wdata;
      op_be    = req_be;
    end else if (state == WAIT && cnt == CLAST) begin
      go = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (go && op_we && !op_err && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      a_idx     <= '0;
      a_wdata   <= 32'h0;
      a_be      <= 4'h0;
      a_we      <= 1'b0;
      a_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            a_idx   <= req_idx;
            a_wdata <= req_wdata;
            a_be    <= req_be;
            a_we    <= req_we;
            a_err   <= req_err;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!go) cnt <= cnt + 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
      if (go) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= op_err;
        if (op_err) rsp_rdata <= 32'h0;
        else if (!op_we) rsp_rdata <= mem[op_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=2 and LATENCY=0 instances
// checked every cycle against a transaction-timing model.
module tb_mem_responder;

  localparam int DEPTH = 128;
  localparam int L0 = 2;
  localparam int L1 = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        re    [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        busy  [2];
  logic        vld   [2];
  logic        err   [2];
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(L0), .INIT_FILE("")) u0 (
    .clk(clk), .rst(rst),
    .req_re(re[0]), .req_we(we[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0]), .req_be(be[0]),
    .busy(busy[0]), .rsp_valid(vld[0]),
    .rsp_rdata(rdata[0]), .rsp_err(err[0])
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(L1), .INIT_FILE("")) u1 (
    .clk(clk), .rst(rst),
    .req_re(re[1]), .req_we(we[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .req_be(be[1]),
    .busy(busy[1]), .rsp_valid(vld[1]),
    .rsp_rdata(rdata[1]), .rsp_err(err[1])
  );

  int tests = 0;
  int fails = 0;
  int ecnt = 0;

  bit          pend    [2];
  int          k       [2];
  logic [31:0] o_addr  [2];
  logic [31:0] o_wdata [2];
  logic [3:0]  o_be    [2];
  bit          o_we    [2];
  bit          o_err   [2];
  bit          x_busy  [2];
  bit          x_vld   [2];
  bit          x_err   [2];
  logic [31:0] x_rdata [2];
  logic [31:0] mm [2][DEPTH];

  logic        s_vld   [2];
  logic        s_err   [2];
  logic [31:0] s_rdata [2];

  function automatic int latf(input int i);
    return (i == 0) ? L0 : L1;
  endfunction

  function automatic bit is_err(input logic r, input logic w,
                                input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4)) || (r && w);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i]    = 0;
      x_busy[i]  = 0;
      x_vld[i]   = 0;
      x_err[i]   = 0;
      x_rdata[i] = 32'h0;
    end
  endtask

  // Accept at edge k, respond at edge k+LAT, free again at k+LAT+1.
  task automatic model_edge(input int i);
    bit was;
    int idx;
    logic [31:0] w;
    was = pend[i];
    x_vld[i] = 0;
    if (was && ecnt == k[i] + latf(i) + 1) begin
      pend[i]   = 0;
      x_busy[i] = 0;
    end
    if (!was && (re[i] || we[i])) begin
      pend[i]    = 1;
      k[i]       = ecnt;
      o_addr[i]  = addr[i];
      o_wdata[i] = wdata[i];
      o_be[i]    = be[i];
      o_we[i]    = we[i];
      o_err[i]   = is_err(re[i], we[i], addr[i]);
      x_busy[i]  = 1;
    end
    if (pend[i] && ecnt == k[i] + latf(i)) begin
      x_vld[i] = 1;
      x_err[i] = o_err[i];
      idx = int'(o_addr[i] >> 2);
      if (o_err[i]) begin
        x_rdata[i] = 32'h0;
      end else if (o_we[i]) begin
        w = mm[i][idx];
        for (int b = 0; b < 4; b++)
          if (o_be[i][b]) w[8*b +: 8] = o_wdata[i][8*b +: 8];
        mm[i][idx] = w;
      end else begin
        x_rdata[i] = mm[i][idx];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d@%0d", i, ecnt), 32'(busy[i]), 32'(x_busy[i]));
      chk($sformatf("valid%0d@%0d", i, ecnt), 32'(vld[i]), 32'(x_vld[i]));
      chk($sformatf("err%0d@%0d", i, ecnt), 32'(err[i]), 32'(x_err[i]));
      chk($sformatf("rdata%0d@%0d", i, ecnt), rdata[i], x_rdata[i]);
      s_vld[i]   = vld[i];
      s_err[i]   = err[i];
      s_rdata[i] = rdata[i];
    end
    @(posedge clk);
    ecnt++;
    if (!rst) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
  endtask

  task automatic txn(input int i, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output int lat,
                     output logic [31:0] rd, output logic er);
    re[i] = r; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    tick();
    re[i] = 0; we[i] = 0;
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (s_vld[i]) begin
        lat = n; rd = s_rdata[i]; er = s_err[i];
        break;
      end
    end
    tests++;
    if (lat < 0) begin
      fails++;
      $display("FAIL txn%0d_timeout: no rsp_valid in 20 cycles", i);
    end
  endtask

  task automatic b2b(input int i, input logic [31:0] a0,
                     input logic [31:0] a1, input logic [31:0] e0,
                     input logic [31:0] e1);
    int p [2];
    logic [31:0] rd [2];
    int np;
    np = 0; p[0] = -1; p[1] = -1; rd[0] = 0; rd[1] = 0;
    re[i] = 1; we[i] = 0; addr[i] = a0;
    tick();
    addr[i] = a1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (s_vld[i]) begin
        p[np] = n; rd[np] = s_rdata[i]; np++;
        if (np == 2) break;
      end
    end
    re[i] = 0;
    repeat (4) tick();
    chk($sformatf("b2b%0d_lat", i), 32'(p[0]), 32'(latf(i) + 1));
    chk($sformatf("b2b%0d_gap", i), 32'(p[1] - p[0]), 32'(latf(i) + 2));
    chk($sformatf("b2b%0d_rd0", i), rd[0], e0);
    chk($sformatf("b2b%0d_rd1", i), rd[1], e1);
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    logic er;
    int pulses;
    int r, q;
    for (int i = 0; i < 2; i++) begin
      re[i] = 0; we[i] = 0; addr[i] = 0; wdata[i] = 0; be[i] = 0;
    end
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy", 32'(busy[0]), 32'h0);
    chk("reset_valid", 32'(vld[0]), 32'h0);
    chk("reset_err", 32'(err[1]), 32'h0);
    chk("reset_rdata", rdata[1], 32'h0);

    for (int i = 0; i < 2; i++)
      for (int wd = 0; wd < DEPTH; wd++)
        txn(i, 0, 1, 32'(wd * 4), $urandom, 4'hF, lat, rd, er);

    txn(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, lat, rd, er);
    chk("t1_wr_lat", 32'(lat), 32'd3);
    chk("t1_wr_err", 32'(er), 32'h0);
    txn(0, 1, 0, 32'h100, 32'h0, 4'h0, lat, rd, er);
    chk("t1_rd_lat", 32'(lat), 32'd3);
    chk("t1_rd_data", rd, 32'hDEADBEEF);

    txn(0, 0, 1, 32'h100, 32'h11223344, 4'b0101, lat, rd, er);
    txn(0, 1, 0, 32'h100, 32'h0, 4'h0, lat, rd, er);
    chk("t2_be_merge", rd, 32'hDE22BE44);
    txn(0, 0, 1, 32'h100, 32'h0, 4'b0000, lat, rd, er);
    chk("t2_be0_err", 32'(er), 32'h0);
    txn(0, 1, 0, 32'h100, 32'h0, 4'h0, lat, rd, er);
    chk("t2_be0_data", rd, 32'hDE22BE44);

    txn(0, 0, 1, 32'h0, 32'h0BADF00D, 4'hF, lat, rd, er);
    txn(0, 1, 0, 32'h102, 32'h0, 4'h0, lat, rd, er);
    chk("t3_mis_err", 32'(er), 32'h1);
    chk("t3_mis_rd", rd, 32'h0);
    chk("t3_mis_lat", 32'(lat), 32'd3);
    txn(0, 1, 0, 32'(DEPTH * 4), 32'h0, 4'h0, lat, rd, er);
    chk("t3_oob_err", 32'(er), 32'h1);
    chk("t3_oob_lat", 32'(lat), 32'd3);
    txn(0, 1, 1, 32'h0, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    chk("t3_both_err", 32'(er), 32'h1);
    chk("t3_both_rd", rd, 32'h0);
    txn(0, 1, 0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    chk("t3_word0", rd, 32'h0BADF00D);

    txn(0, 0, 1, 32'h4, 32'h44444444, 4'hF, lat, rd, er);
    txn(0, 0, 1, 32'h8, 32'h88888888, 4'hF, lat, rd, er);
    re[0] = 1; addr[0] = 32'h4;
    tick();
    re[0] = 0; we[0] = 1; addr[0] = 32'h8;
    wdata[0] = 32'h12345678; be[0] = 4'hF;
    chk("t4_busy", 32'(busy[0]), 32'h1);
    tick();
    we[0] = 0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (s_vld[0]) pulses++;
    end
    chk("t4_pulses", 32'(pulses), 32'd1);
    txn(0, 1, 0, 32'h8, 32'h0, 4'h0, lat, rd, er);
    chk("t4_ignored", rd, 32'h88888888);

    txn(0, 0, 1, 32'h20, 32'h20202020, 4'hF, lat, rd, er);
    we[0] = 1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
    tick();
    we[0] = 0;
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_busy_now", 32'(busy[0]), 32'h0);
    chk("t5_valid_now", 32'(vld[0]), 32'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    txn(0, 1, 0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    chk("t5_no_commit", rd, 32'h20202020);

    txn(1, 0, 1, 32'h0, 32'h01234567, 4'hF, lat, rd, er);
    chk("t6_wr_lat", 32'(lat), 32'd1);
    txn(1, 0, 1, 32'h4, 32'h89ABCDEF, 4'hF, lat, rd, er);
    b2b(1, 32'h0, 32'h4, 32'h01234567, 32'h89ABCDEF);
    b2b(0, 32'h0, 32'h4, 32'h0BADF00D, 32'h44444444);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        r = $urandom_range(0, 99);
        re[i] = (r < 35) || (r >= 95);
        we[i] = (r >= 35 && r < 60) || (r >= 95);
        q = $urandom_range(0, 19);
        if (q == 0)
          addr[i] = {23'h0, 7'($urandom_range(0, DEPTH - 1)),
                     2'($urandom_range(1, 3))};
        else if (q == 1)
          addr[i] = 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
        else if (q < 10)
          addr[i] = 32'($urandom_range(0, 15) * 4);
        else
          addr[i] = 32'($urandom_range(0, DEPTH - 1) * 4);
        wdata[i] = $urandom;
        be[i] = 4'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    for (int i = 0; i < 2; i++) begin
      re[i] = 0; we[i] = 0;
    end
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
